// File: rtl/load_store_unit.sv
// Load/store unit for a multicycle RISC-V core: sequences byte, halfword and word
// accesses to a word-wide data memory with lane merge on stores and extension on loads.
module load_store_unit #(
  parameter int unsigned SW_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned LANES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic            st_q;

  logic            accept;
  logic            req_illegal;
  logic            req_misaligned;
  logic            req_bad;
  logic            req_bypass;

  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] store_merged;

  assign mem_A  = {addr_q[XLEN-1:2], 2'b00};
  assign accept = (state == IDLE) && start;

  // Request classification on the raw inputs, evaluated while idle.
  always_comb begin
    req_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (is_store && funct3[2]);
    req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    req_bad        = req_illegal || req_misaligned;
    req_bypass     = (SW_BYPASS != 0) && is_store && (funct3 == F3_W);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (req_bad) begin
            state_next = ERR;
          end else if (req_bypass) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = st_q ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs; mem_WE decodes the state register so reset clears it at once.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    mem_WE = 1'b0;
    unique case (state)
      IDLE: ;
      RD:   busy = 1'b1;
      WR: begin
        busy   = 1'b1;
        mem_WE = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ERR: begin
        busy = 1'b1;
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Lane selection for loads.
  always_comb begin
    rd_byte = mem_RD[7:0];
    unique case (addr_q[1:0])
      2'd0: rd_byte = mem_RD[7:0];
      2'd1: rd_byte = mem_RD[15:8];
      2'd2: rd_byte = mem_RD[23:16];
      2'd3: rd_byte = mem_RD[31:24];
      default: rd_byte = mem_RD[7:0];
    endcase
    rd_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];

    load_ext = mem_RD;
    unique case (f3_q)
      F3_B:    load_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      F3_H:    load_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
      F3_BU:   load_ext = {(XLEN-8)'(0), rd_byte};
      F3_HU:   load_ext = {(XLEN-16)'(0), rd_half};
      default: load_ext = mem_RD;
    endcase
  end

  // Read-modify-write merge of the store data into the addressed lanes.
  always_comb begin
    store_merged = mem_RD;
    unique case (f3_q[1:0])
      2'b00: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (addr_q[1:0] == 2'(i)) begin
            store_merged[8*i +: 8] = wdata_q[7:0];
          end
        end
      end
      2'b01: begin
        if (addr_q[1]) begin
          store_merged[31:16] = wdata_q[15:0];
        end else begin
          store_merged[15:0] = wdata_q[15:0];
        end
      end
      default: store_merged = wdata_q;
    endcase
  end

  // Request capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      rdata   <= '0;
      mem_WD  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        f3_q    <= funct3;
        st_q    <= is_store;
        if (req_bypass && !req_bad) begin
          mem_WD <= wdata;
        end
      end
      if (state == RD) begin
        if (st_q) begin
          mem_WD <= store_merged;
        end else begin
          rdata <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];
  int          we_cnt;
  int          done_cnt;
  logic [31:0] last_a;
  logic [31:0] last_wd;

  int checks;
  int errors;

  int   lat;
  logic e;
  logic we1;
  int   we_base;
  int   done_base;

  load_store_unit #(.SW_BYPASS(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mem_A    (mem_a),
    .mem_WD   (mem_wd),
    .mem_WE   (mem_we),
    .mem_RD   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = (mem_a[31:10] == 22'd0) ? mem[mem_a[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a[31:10] == 22'd0) mem[mem_a[9:2]] <= mem_wd;
      we_cnt  <= we_cnt + 1;
      last_a  <= mem_a;
      last_wd <= mem_wd;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from an idle negedge; returns latency, err and mem_WE one cycle after start.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int l, output logic ev,
                         output logic w1);
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l  = 1;
    w1 = mem_we;
    while (!done && l < 8) begin
      @(negedge clk);
      l++;
    end
    ev = err;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    we_cnt   = 0;
    done_cnt = 0;
    last_a   = '0;
    last_wd  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h8899AABB;
    rst_n    = 1'b0;
    start    = 1'b0;
    is_store = 1'b0;
    funct3   = 3'b000;
    addr     = 32'h0;
    wdata    = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wd", mem_wd, 32'h0);
    check("rst_a", mem_a, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(1'b0, 3'b000, 32'h102, 32'h0, lat, e, we1);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_err", 32'(e), 32'd0);
    check("lb_rdata", rdata, 32'hFFFFFF99);

    run_req(1'b0, 3'b100, 32'h102, 32'h0, lat, e, we1);
    check("lbu_rdata", rdata, 32'h00000099);

    run_req(1'b0, 3'b001, 32'h102, 32'h0, lat, e, we1);
    check("lh_rdata", rdata, 32'hFFFF8899);

    run_req(1'b0, 3'b101, 32'h100, 32'h0, lat, e, we1);
    check("lhu_rdata", rdata, 32'h0000AABB);
    check("ld_no_we", 32'(we_cnt), 32'd0);

    we_base = we_cnt;
    run_req(1'b1, 3'b000, 32'h101, 32'h12345677, lat, e, we1);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_cnt", 32'(we_cnt - we_base), 32'd1);
    check("sb_mem_a", last_a, 32'h100);
    check("sb_mem_wd", last_wd, 32'h889977BB);
    check("sb_rdata_hold", rdata, 32'h0000AABB);

    run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, e, we1);
    check("sb_readback", rdata, 32'h889977BB);

    run_req(1'b1, 3'b001, 32'h102, 32'h0000CAFE, lat, e, we1);
    check("sh_lat", 32'(lat), 32'd3);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, e, we1);
    check("sh_readback", rdata, 32'hCAFE77BB);

    we_base = we_cnt;
    run_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, lat, e, we1);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_first", 32'(we1), 32'd1);
    check("sw_we_cnt", 32'(we_cnt - we_base), 32'd1);
    check("sw_mem", mem[65], 32'hDEADBEEF);

    we_base = we_cnt;
    run_req(1'b0, 3'b010, 32'h106, 32'h0, lat, e, we1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_err", 32'(e), 32'd1);
    check("lw_mis_rdata", rdata, 32'hCAFE77BB);

    run_req(1'b0, 3'b001, 32'h101, 32'h0, lat, e, we1);
    check("lh_mis_err", 32'(e), 32'd1);
    run_req(1'b0, 3'b011, 32'h100, 32'h0, lat, e, we1);
    check("ill_f3_err", 32'(e), 32'd1);
    run_req(1'b1, 3'b100, 32'h100, 32'h11, lat, e, we1);
    check("ill_st_lat", 32'(lat), 32'd1);
    check("ill_st_err", 32'(e), 32'd1);
    check("err_no_we", 32'(we_cnt - we_base), 32'd0);
    check("err_mem", mem[64], 32'hCAFE77BB);

    // Reset asserted while the sb is in WR.
    we_base   = we_cnt;
    done_base = done_cnt;
    is_store = 1'b1;
    funct3   = 3'b000;
    addr     = 32'h100;
    wdata    = 32'h00000055;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstwr_we_on", 32'(mem_we), 32'd1);
    check("rstwr_wd", mem_wd, 32'hCAFE7755);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_we_off", 32'(mem_we), 32'd0);
    check("rstwr_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("rstwr_mem", mem[64], 32'hCAFE77BB);
    check("rstwr_we_cnt", 32'(we_cnt - we_base), 32'd0);
    check("rstwr_no_done", 32'(done_cnt - done_base), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start held high while busy yields a single completion.
    done_base = done_cnt;
    is_store = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h104;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("hold_rdata", rdata, 32'hDEADBEEF);
    check("hold_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: SW_BYPASS, default 1, meaning that when 1 a word store skips the read phase.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request strobe from the multicycle controller; sampled only in IDLE.
REQ-005 Port: is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 Port: funct3  input  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 Port: addr  input  32  byte address.
REQ-008 Port: wdata  input  32  store data; low byte or halfword used for sb/sh.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: err  output  1  valid with done; 1 = misaligned or illegal request.
REQ-012 Port: rdata  output  32  extended load result; holds until the next load completes.
REQ-013 Port: mem_A  output  32  word address to the data memory, always {addr_q[31:2],2'b00}.
REQ-014 Port: mem_WD  output  32  merged write word.
REQ-015 Port: mem_WE  output  1  write enable to the data memory.
REQ-016 Port: mem_RD  input  32  combinational little-endian read word from the data memory.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, RD, WR, DONE, ERR.
REQ-018 In IDLE with start=1, the block SHALL register addr, wdata, funct3 and is_store into addr_q, wdata_q, f3_q and st_q.
REQ-019 Transitions out of IDLE on start=1 SHALL be:
  - misaligned or illegal request -> ERR;
  - sw with SW_BYPASS=1 -> WR;
  - any other request -> RD.
REQ-020 Misaligned SHALL mean: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 Illegal SHALL mean: funct3 of 011, 110 or 111; or a store with funct3 100 or 101.
REQ-022 RD state, load: capture mem_RD, select the byte or halfword by addr_q[1:0] (byte n = bits 8n+7:8n), sign-extend for b/h or zero-extend for bu/hu, write the result to rdata, go to DONE.
REQ-023 RD state, store: merge wdata_q into the addressed lane(s) of mem_RD (sb 1 lane, sh 2 lanes, sw all 4), register the word as mem_WD, go to WR.
REQ-024 WR state SHALL assert mem_WE=1 for exactly one cycle, then go to DONE.
REQ-025 For a bypassed sw, mem_WD SHALL equal wdata_q.
REQ-026 DONE state SHALL assert done=1 with err=0 for one cycle, then return to IDLE.
REQ-027 ERR state SHALL assert done=1 and err=1 for one cycle, then return to IDLE; no memory write and no rdata update.
REQ-028 Latency, measured from the edge sampling start to the cycle with done high: load 2 cycles; sb/sh 3 cycles; sw 2 cycles (SW_BYPASS=1) or 3 cycles (SW_BYPASS=0); error 1 cycle.
REQ-029 start SHALL be ignored whenever busy=1; back-to-back requests are accepted only from the cycle after done.
REQ-030 mem_WE SHALL be a Moore output of WR only; it is never high in any other state.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in IDLE.
REQ-032 While rst_n=0, busy, done, err and mem_WE SHALL be 0, and rdata, mem_WD, addr_q, wdata_q and f3_q SHALL be 0.
REQ-033 Reset asserted mid-operation, including in WR, SHALL drop mem_WE immediately (asynchronously) and abandon the request with no done pulse.

Verification
REQ-034 Memory word 0x100 = 0x8899AABB; lb at addr 0x102 -> done 2 cycles after start, rdata = 0xFFFFFF99; lbu at the same address -> rdata = 0x00000099.
REQ-035 Same word; lh at 0x102 -> rdata = 0xFFFF8899; lhu at 0x100 -> rdata = 0x0000AABB.
REQ-036 Same word; sb wdata = 0x12345677 at 0x101 -> single mem_WE pulse with mem_A = 0x100 and mem_WD = 0x8899 77BB, read back as 0x889977BB; then sh 0xCAFE at 0x102 -> 0xCAFE77BB.
REQ-037 sw 0xDEADBEEF at 0x104 with SW_BYPASS=1 -> mem_WE in the cycle after start, done the cycle after that.
REQ-038 lw at 0x106 -> done=1, err=1 one cycle after start, mem_WE never asserted, rdata unchanged.
REQ-039 Reset during WR of an sb -> mem_WE low immediately and memory unchanged; start held high while busy -> exactly one done pulse.
